// File: rtl/exu_issue_ctrl_pkg.sv
// Shared types and default sizes for the EXU issue controller.
package exu_issue_ctrl_pkg;

    localparam int unsigned ISSUE_AW    = 32;
    localparam int unsigned ISSUE_DW    = 32;
    localparam int unsigned ISSUE_DEPTH = 4;

    // One buffered fetch slot.
    typedef struct packed {
        logic [ISSUE_AW-1:0] pc;
        logic [ISSUE_DW-1:0] ir;
    } issue_ent_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REDIR  = 2'd1,
        SETTLE = 2'd2
    } issue_state_e;

endpackage

// File: rtl/exu_issue_ctrl_issue_fifo.sv
// In-order issue queue: DEPTH entries, wrapping pointers, flush clears everything.
module issue_fifo
    import exu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = ISSUE_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  issue_ent_t wr_data,
    input  logic       rd_en,
    input  logic       flush,
    output issue_ent_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    issue_ent_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en & ~full & ~flush;
    assign rd_ok   = rd_en & ~empty & ~flush;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue sequencer between fetch and EXU: queues {pc, ir}, issues in order,
// flushes and redirects fetch on a taken EXU response.
// Optional macro EXU_ISSUE_BYPASS_EN: zero-latency issue straight from fetch
// when the queue is empty.
module exu_issue_ctrl
    import exu_issue_ctrl_pkg::*;
#(
    parameter int unsigned AW    = ISSUE_AW,
    parameter int unsigned DW    = ISSUE_DW,
    parameter int unsigned DEPTH = ISSUE_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ifu_vld,
    output logic          ifu_rdy,
    input  logic [AW-1:0] ifu_pc,
    input  logic [DW-1:0] ifu_ir,
    output logic          exu_req_vld,
    input  logic          exu_req_rdy,
    output logic [AW-1:0] exu_req_pc,
    output logic [DW-1:0] exu_req_ir,
    input  logic          exu_rsp_taken,
    input  logic [AW-1:0] exu_rsp_offset,
    output logic          redir_vld,
    output logic [AW-1:0] redir_pc,
    output logic          busy
);

    issue_state_e  state_q;
    issue_state_e  state_d;
    logic          rdy_en_q;
    logic          redir_vld_q;
    logic          redir_vld_d;
    logic [AW-1:0] redir_pc_q;
    logic [AW-1:0] redir_pc_d;
    logic          flush_c;

    issue_ent_t    wr_ent;
    issue_ent_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          run;
    logic          byp;
    logic          enq;
    logic          deq;

    assign run = (state_q == RUN);

`ifdef EXU_ISSUE_BYPASS_EN
    assign byp = rdy_en_q & run & fifo_empty & ifu_vld;
`else
    assign byp = 1'b0;
`endif

    assign ifu_rdy     = rdy_en_q & run & ~fifo_full;
    assign exu_req_vld = run & (~fifo_empty | byp);
    assign exu_req_pc  = byp ? ifu_pc : head.pc;
    assign exu_req_ir  = byp ? ifu_ir : head.ir;
    assign enq         = ifu_vld & ifu_rdy;
    assign deq         = exu_req_vld & exu_req_rdy;
    assign busy        = ~fifo_empty | ~run;
    assign redir_vld   = redir_vld_q;
    assign redir_pc    = redir_pc_q;
    assign wr_ent      = '{pc: ifu_pc, ir: ifu_ir};

    // A bypassed instruction the EXU accepts never enters the queue.
    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (enq & ~(byp & exu_req_rdy)),
        .wr_data (wr_ent),
        .rd_en   (deq & ~byp),
        .flush   (flush_c),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State, redirect register and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            rdy_en_q    <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    // Next state: taken issue flushes and enters REDIR, then SETTLE absorbs stale fetch.
    always_comb begin
        state_d     = state_q;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;
        flush_c     = 1'b0;
        case (state_q)
            RUN: begin
                if (deq & exu_rsp_taken) begin
                    flush_c     = 1'b1;
                    redir_vld_d = 1'b1;
                    redir_pc_d  = exu_req_pc + exu_rsp_offset;
                    state_d     = REDIR;
                end
            end
            REDIR:   state_d = SETTLE;
            SETTLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Scoreboard bench for exu_issue_ctrl against a queue-based reference model.
// Honours EXU_ISSUE_BYPASS_EN in the model when the DUT is built with it.
module tb_exu_issue_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_vld = 1'b0;
    logic        ifu_rdy;
    logic [31:0] ifu_pc = '0;
    logic [31:0] ifu_ir = '0;
    logic        exu_req_vld;
    logic        exu_req_rdy = 1'b0;
    logic [31:0] exu_req_pc;
    logic [31:0] exu_req_ir;
    logic        exu_rsp_taken = 1'b0;
    logic [31:0] exu_rsp_offset = '0;
    logic        redir_vld;
    logic [31:0] redir_pc;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Reference model state
    ent_t        mq[$];
    ent_t        sbq[$];
    int          cool = 0;
    bit          m_rdy_en = 0;
    bit          m_rvld = 0;
    logic [31:0] m_rpc = '0;
    bit          last_enq = 0;
    logic [31:0] next_pc = 32'h100;

    exu_issue_ctrl #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_vld        (ifu_vld),
        .ifu_rdy        (ifu_rdy),
        .ifu_pc         (ifu_pc),
        .ifu_ir         (ifu_ir),
        .exu_req_vld    (exu_req_vld),
        .exu_req_rdy    (exu_req_rdy),
        .exu_req_pc     (exu_req_pc),
        .exu_req_ir     (exu_req_ir),
        .exu_rsp_taken  (exu_rsp_taken),
        .exu_rsp_offset (exu_rsp_offset),
        .redir_vld      (redir_vld),
        .redir_pc       (redir_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational view, advance model to next cycle.
    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] ir,
                       input bit rdy, input bit tk, input logic [31:0] off);
        bit   m_run, m_rdy, m_byp, m_vld, enq, deq;
        ent_t head;
        ifu_vld        = v;
        ifu_pc         = pc;
        ifu_ir         = ir;
        exu_req_rdy    = rdy;
        exu_rsp_taken  = tk;
        exu_rsp_offset = off;
        #1;
        m_run = (cool == 0);
        m_rdy = m_rdy_en && m_run && (mq.size() < DEPTH);
        m_byp = 0;
`ifdef EXU_ISSUE_BYPASS_EN
        m_byp = m_run && m_rdy_en && (mq.size() == 0) && v;
`endif
        m_vld = m_run && ((mq.size() > 0) || m_byp);
        head.pc = '0;
        head.ir = '0;
        if (m_byp) begin
            head.pc = pc;
            head.ir = ir;
        end else if (mq.size() > 0) begin
            head = mq[0];
        end
        chk("ifu_rdy", 32'(ifu_rdy), 32'(m_rdy));
        chk("exu_req_vld", 32'(exu_req_vld), 32'(m_vld));
        chk("busy", 32'(busy), 32'((mq.size() > 0) || (cool > 0)));
        chk("redir_vld", 32'(redir_vld), 32'(m_rvld));
        chk("redir_pc", redir_pc, m_rpc);
        if (m_vld) begin
            chk("exu_req_pc", exu_req_pc, head.pc);
            chk("exu_req_ir", exu_req_ir, head.ir);
        end
        enq = v && m_rdy;
        deq = m_vld && rdy;
        if (deq) sbq.push_back(head);
        if (deq && tk) begin
            mq.delete();
            cool  = 2;
            m_rpc = head.pc + off;
        end else begin
            if (deq && !m_byp) void'(mq.pop_front());
            if (enq && !(m_byp && deq)) mq.push_back('{pc, ir});
            if (cool > 0) cool--;
        end
        m_rvld   = (cool == 2);
        m_rdy_en = 1;
        last_enq = enq;
        @(negedge clk);
    endtask

    // Offer the next sequential PC; advance only when the model says it was accepted.
    task automatic stream(input bit v, input bit rdy, input bit tk, input logic [31:0] off);
        cyc(v, next_pc, next_pc ^ 32'h0000_0013, rdy, tk, off);
        if (last_enq) next_pc += 32'd4;
    endtask

    // Asynchronous reset pulse starting just after a negedge; releases on a negedge.
    task automatic do_reset();
        ifu_vld     = 0;
        exu_req_rdy = 0;
        rst_n       = 0;
        #1;
        chk("rst_ifu_rdy", 32'(ifu_rdy), 32'd0);
        chk("rst_exu_req_vld", 32'(exu_req_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_redir_vld", 32'(redir_vld), 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        mq.delete();
        cool     = 0;
        m_rdy_en = 0;
        m_rvld   = 0;
        m_rpc    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: pop expected issue whenever the DUT handshakes with the EXU.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && exu_req_vld && exu_req_rdy) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_issue: got pc %h expected no issue", exu_req_pc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_pc", exu_req_pc, e.pc);
                    chk("sb_ir", exu_req_ir, e.ir);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // First cycle after release: not ready; then enqueue and issue
        cyc(1, 32'h100, 32'h13, 1, 0, 0);
        cyc(1, 32'h100, 32'h13, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 0);

        // Fill past DEPTH with EXU stalled, then drain in order
        next_pc = 32'h100;
        repeat (6) stream(1, 0, 0, 0);
        repeat (6) stream(0, 1, 0, 0);

        // Taken at head 0x200 with 2 queued and a same-cycle enqueue offered
        next_pc = 32'h200;
        repeat (2) stream(1, 0, 0, 0);
        stream(1, 1, 1, 32'h10);
        chk("taken_redir_pc", redir_pc, 32'h210);
        repeat (4) stream(1, 1, 0, 0);
        repeat (4) stream(0, 1, 0, 0);

        // Redirect target wraps around the address space
        next_pc = 32'hFFFF_FFF8;
        stream(1, 0, 0, 0);
        stream(0, 1, 1, 32'h10);
        chk("wrap_redir_pc", redir_pc, 32'h0000_0008);

        // Reset with entries queued, then again while in REDIR
        next_pc = 32'h400;
        repeat (3) stream(1, 0, 0, 0);
        do_reset();
        repeat (3) stream(0, 1, 0, 0);
        repeat (2) stream(1, 0, 0, 0);
        stream(0, 1, 1, 32'h40);
        do_reset();
        repeat (3) stream(0, 1, 0, 0);

        // Bypass candidate: empty queue, EXU ready
        next_pc = 32'h300;
        stream(1, 1, 0, 0);
        repeat (3) stream(0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          v, r, t;
            logic [31:0] off;
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 2) != 0);
            t   = ($urandom_range(0, 9) == 0);
            off = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                stream(v, r, t, off);
            end
        end

        repeat (8) stream(0, 1, 0, 0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
